// File: rtl/srp16_regbus_pkg.sv
// Shared types for the register-bus controller: access opcodes and FSM states.
package srp16_regbus_pkg;

    typedef enum logic [1:0] {
        OP_READ   = 2'b00,
        OP_WRITE  = 2'b01,
        OP_WRITEU = 2'b10,
        OP_MOVE   = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_XFER  = 3'd1,
        ST_MV_RD = 3'd2,
        ST_MV_WR = 3'd3,
        ST_ACK   = 3'd4
    } state_e;

    localparam int DW = 16;

endpackage

// File: rtl/regbus_ctrl_arb.sv
// Two-way round-robin arbiter; the tie-break pointer moves only when update is high.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    // Set when requester 1 should win the next tie.
    logic r_prio1;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = r_prio1 ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio1 <= 1'b0;
        end else if (update && (grant != 2'b00)) begin
            r_prio1 <= grant[0];
        end
    end

endmodule

// File: rtl/regbus_ctrl.sv
// Register-bus controller: arbitrates two requesters and sequences READ, WRITE,
// WRITEU and MOVE accesses onto a shared tri-state register bus.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | sample requests, latch winner's op/src/dst/wdata
// XFER     | single-cycle READ / WRITE / WRITEU bus access
// MV_RD    | MOVE phase 1: source drives bus, value captured to temp
// MV_WR    | MOVE phase 2: controller drives temp into destination
// ACK      | one-cycle ack to the winner, then back to IDLE
module regbus_ctrl
    import srp16_regbus_pkg::*;
#(
    parameter  int AW   = 3,
    localparam int NREG = 2**AW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0,
    input  logic            req1,
    input  logic [1:0]      op0,
    input  logic [1:0]      op1,
    input  logic [AW-1:0]   src0,
    input  logic [AW-1:0]   src1,
    input  logic [AW-1:0]   dst0,
    input  logic [AW-1:0]   dst1,
    input  logic [DW-1:0]   wdata0,
    input  logic [DW-1:0]   wdata1,
    output logic [1:0]      ack,
    output logic [DW-1:0]   rdata,
    input  logic [DW-1:0]   bus_in,
    output logic [DW-1:0]   bus_out,
    output logic            bus_oe,
    output logic [NREG-1:0] reg_read,
    output logic [NREG-1:0] reg_write,
    output logic [NREG-1:0] reg_writeu,
    output logic            busy
);

    state_e          r_state;
    op_e             r_op;
    logic [AW-1:0]   r_src;
    logic [AW-1:0]   r_dst;
    logic [DW-1:0]   r_wdata;
    logic [DW-1:0]   r_temp;
    logic [DW-1:0]   r_rdata;
    logic            r_winner;

    logic [1:0]      w_grant;
    logic            w_update;
    logic            w_sel1;
    op_e             w_op;
    logic [AW-1:0]   w_src;
    logic [AW-1:0]   w_dst;
    logic [DW-1:0]   w_wdata;
    logic [NREG-1:0] w_src_oh;
    logic [NREG-1:0] w_dst_oh;

    assign w_update = (r_state == ST_IDLE);

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    ({req1, req0}),
        .update (w_update),
        .grant  (w_grant)
    );

    assign w_sel1  = w_grant[1];
    assign w_op    = op_e'(w_sel1 ? op1 : op0);
    assign w_src   = w_sel1 ? src1 : src0;
    assign w_dst   = w_sel1 ? dst1 : dst0;
    assign w_wdata = w_sel1 ? wdata1 : wdata0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_op     <= OP_READ;
            r_src    <= '0;
            r_dst    <= '0;
            r_wdata  <= '0;
            r_temp   <= '0;
            r_rdata  <= '0;
            r_winner <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant != 2'b00) begin
                        r_op     <= w_op;
                        r_src    <= w_src;
                        r_dst    <= w_dst;
                        r_wdata  <= w_wdata;
                        r_winner <= w_sel1;
                        r_state  <= (w_op == OP_MOVE) ? ST_MV_RD : ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (r_op == OP_READ) begin
                        r_rdata <= bus_in;
                    end
                    r_state <= ST_ACK;
                end
                ST_MV_RD: begin
                    r_temp  <= bus_in;
                    r_state <= ST_MV_WR;
                end
                ST_MV_WR: r_state <= ST_ACK;
                ST_ACK:   r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    // Strobes and bus drive decode only flopped state and latched fields, so
    // nothing here can glitch on requester inputs.
    assign w_src_oh = NREG'(1) << r_src;
    assign w_dst_oh = NREG'(1) << r_dst;

    always_comb begin
        reg_read   = '0;
        reg_write  = '0;
        reg_writeu = '0;
        bus_oe     = 1'b0;
        bus_out    = '0;
        case (r_state)
            ST_XFER: begin
                case (r_op)
                    OP_READ:   reg_read = w_src_oh;
                    OP_WRITE: begin
                        reg_write = w_dst_oh;
                        bus_oe    = 1'b1;
                        bus_out   = r_wdata;
                    end
                    OP_WRITEU: begin
                        reg_writeu = w_dst_oh;
                        bus_oe     = 1'b1;
                        bus_out    = r_wdata;
                    end
                    default: ;
                endcase
            end
            ST_MV_RD: reg_read = w_src_oh;
            ST_MV_WR: begin
                reg_write = w_dst_oh;
                bus_oe    = 1'b1;
                bus_out   = r_temp;
            end
            default: ;
        endcase
    end

    assign ack   = (r_state == ST_ACK) ? (r_winner ? 2'b10 : 2'b01) : 2'b00;
    assign busy  = (r_state != ST_IDLE);
    assign rdata = r_rdata;

endmodule

// File: tb/tb_regbus_ctrl.sv
// Directed self-checking bench for regbus_ctrl with a per-cycle bus-safety check.
module tb_regbus_ctrl;

    localparam int AW   = 3;
    localparam int NREG = 8;

    logic            clk;
    logic            rst_n;
    logic            req0, req1;
    logic [1:0]      op0, op1;
    logic [AW-1:0]   src0, src1, dst0, dst1;
    logic [15:0]     wdata0, wdata1;
    logic [1:0]      ack;
    logic [15:0]     rdata;
    logic [15:0]     bus_in;
    logic [15:0]     bus_out;
    logic            bus_oe;
    logic [NREG-1:0] reg_read, reg_write, reg_writeu;
    logic            busy;

    int errors = 0;
    int checks = 0;

    regbus_ctrl #(.AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0       (req0),
        .req1       (req1),
        .op0        (op0),
        .op1        (op1),
        .src0       (src0),
        .src1       (src1),
        .dst0       (dst0),
        .dst1       (dst1),
        .wdata0     (wdata0),
        .wdata1     (wdata1),
        .ack        (ack),
        .rdata      (rdata),
        .bus_in     (bus_in),
        .bus_out    (bus_out),
        .bus_oe     (bus_oe),
        .reg_read   (reg_read),
        .reg_write  (reg_write),
        .reg_writeu (reg_writeu),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_rd"}, 16'(reg_read), 16'h0);
        chk({tag, "_wr"}, 16'(reg_write), 16'h0);
        chk({tag, "_wu"}, 16'(reg_writeu), 16'h0);
        chk({tag, "_oe"}, 16'(bus_oe), 16'h0);
    endtask

    // At most one strobe bit overall, and no read strobe while the controller drives.
    always @(negedge clk) begin
        checks++;
        assert (($countones({reg_read, reg_write, reg_writeu}) <= 1) && !((|reg_read) && bus_oe))
        else begin
            errors++;
            $error("FAIL bus_safety: rd=%h wr=%h wu=%h oe=%b", reg_read, reg_write, reg_writeu, bus_oe);
        end
    end

    initial begin
        rst_n = 1'b0;
        req0 = 0; req1 = 0; op0 = 0; op1 = 0;
        src0 = 0; src1 = 0; dst0 = 0; dst1 = 0;
        wdata0 = 0; wdata1 = 0; bus_in = 0;

        repeat (2) tick();
        chk_quiet("rst");
        chk("rst_ack", 16'(ack), 16'h0);
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_rdata", rdata, 16'h0);
        chk("rst_bus_out", bus_out, 16'h0);

        // WRITE dst=3 from requester 0
        @(negedge clk);
        rst_n = 1'b1;
        req0 = 1; op0 = 2'b01; dst0 = 3'd3; wdata0 = 16'hBEEF;
        tick();
        chk("wr_strobe", 16'(reg_write), 16'h0008);
        chk("wr_oe", 16'(bus_oe), 16'h1);
        chk("wr_bus_out", bus_out, 16'hBEEF);
        chk("wr_busy", 16'(busy), 16'h1);
        chk("wr_ack_early", 16'(ack), 16'h0);
        tick();
        chk("wr_ack", 16'(ack), 16'h1);
        chk("wr_strobe_off", 16'(reg_write), 16'h0);
        req0 = 0;
        tick();
        chk("wr_idle_ack", 16'(ack), 16'h0);
        chk("wr_idle_busy", 16'(busy), 16'h0);

        // READ src=3 from requester 1
        req1 = 1; op1 = 2'b00; src1 = 3'd3;
        tick();
        chk("rd_strobe", 16'(reg_read), 16'h0008);
        chk("rd_oe", 16'(bus_oe), 16'h0);
        bus_in = 16'hBEEF;
        tick();
        chk("rd_ack", 16'(ack), 16'h2);
        chk("rd_rdata", rdata, 16'hBEEF);
        req1 = 0;
        bus_in = 16'h0000;
        tick();
        chk("rd_hold", rdata, 16'hBEEF);

        // Both requesters held after a fresh reset: grants alternate 0,1,0,1
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        chk("rst2_rdata", rdata, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        req0 = 1; op0 = 2'b01; dst0 = 3'd0; wdata0 = 16'h1111;
        req1 = 1; op1 = 2'b01; dst1 = 3'd1; wdata1 = 16'h2222;
        tick(); chk("rr0_wr", 16'(reg_write), 16'h0001); chk("rr0_bus", bus_out, 16'h1111);
        tick(); chk("rr0_ack", 16'(ack), 16'h1);
        tick(); chk("rr0_idle", 16'(busy), 16'h0);
        tick(); chk("rr1_wr", 16'(reg_write), 16'h0002); chk("rr1_bus", bus_out, 16'h2222);
        tick(); chk("rr1_ack", 16'(ack), 16'h2);
        tick(); chk("rr1_idle", 16'(busy), 16'h0);
        tick(); chk("rr2_wr", 16'(reg_write), 16'h0001);
        tick(); chk("rr2_ack", 16'(ack), 16'h1);
        tick(); chk("rr2_idle", 16'(busy), 16'h0);
        tick(); chk("rr3_wr", 16'(reg_write), 16'h0002);
        tick(); chk("rr3_ack", 16'(ack), 16'h2);
        req0 = 0; req1 = 0;
        tick();

        // MOVE src=2 dst=5; inputs changed mid-flight must be ignored
        req0 = 1; op0 = 2'b11; src0 = 3'd2; dst0 = 3'd5;
        bus_in = 16'h1234;
        tick();
        chk("mv_rd", 16'(reg_read), 16'h0004);
        chk("mv_rd_oe", 16'(bus_oe), 16'h0);
        chk("mv_rd_ack", 16'(ack), 16'h0);
        dst0 = 3'd0; op0 = 2'b00;
        tick();
        bus_in = 16'hFFFF;
        chk("mv_wr", 16'(reg_write), 16'h0020);
        chk("mv_wr_rd", 16'(reg_read), 16'h0);
        chk("mv_wr_oe", 16'(bus_oe), 16'h1);
        chk("mv_wr_bus", bus_out, 16'h1234);
        chk("mv_wr_ack", 16'(ack), 16'h0);
        tick();
        chk("mv_ack", 16'(ack), 16'h1);
        req0 = 0;
        tick();
        chk("mv_rdata_kept", rdata, 16'h0);

        // WRITEU dst=7
        req0 = 1; op0 = 2'b10; dst0 = 3'd7; wdata0 = 16'h00A5;
        tick();
        chk("wu_strobe", 16'(reg_writeu), 16'h0080);
        chk("wu_wr", 16'(reg_write), 16'h0);
        chk("wu_bus", 16'(bus_out[7:0]), 16'h00A5);
        chk("wu_oe", 16'(bus_oe), 16'h1);
        tick();
        chk("wu_ack", 16'(ack), 16'h1);
        req0 = 0;
        tick();

        // WRITE aborted by reset in XFER
        req1 = 1; op1 = 2'b01; dst1 = 3'd4; wdata1 = 16'h5A5A;
        tick();
        chk("ab_wr", 16'(reg_write), 16'h0010);
        #2;
        rst_n = 1'b0;
        #1;
        chk_quiet("ab");
        chk("ab_busy", 16'(busy), 16'h0);
        chk("ab_ack", 16'(ack), 16'h0);
        req1 = 0;
        repeat (2) begin
            tick();
            chk("ab_no_ack", 16'(ack), 16'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("ab_idle", 16'(busy), 16'h0);
        chk("ab_idle_ack", 16'(ack), 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regbus_ctrl.md
REGBUS_CTRL -- requirements
Module: regbus_ctrl

Interface
REQ-001 Parameter AW, default 3, register address width; register count NREG = 2**AW.
REQ-002 clk  input  1  system clock; all state changes on posedge clk.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req0 / req1  input  1 each  access request from requester 0 / 1; held high until the matching ack.
REQ-005 op0 / op1  input  2 each  operation: 00 READ, 01 WRITE, 10 WRITEU, 11 MOVE.
REQ-006 src0 / src1  input  AW each  source register (READ, MOVE).
REQ-007 dst0 / dst1  input  AW each  destination register (WRITE, WRITEU, MOVE).
REQ-008 wdata0 / wdata1  input  16 each  write data (WRITE, WRITEU).
REQ-009 ack  output  2  one-cycle completion pulse; bit i belongs to requester i.
REQ-010 rdata  output  16  read result; valid in the ack cycle of a READ, and held until the next READ completes.
REQ-011 bus_in  input  16  shared register bus (resolved tri-state register outputs).
REQ-012 bus_out / bus_oe  output  16 / 1  controller drive value and drive enable for the shared bus.
REQ-013 reg_read / reg_write / reg_writeu  output  NREG each  per-register strobes: bus drive, full write, upper-byte write (register loads din[7:0] into [15:8]).
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 FSM states: IDLE, XFER, MV_RD, MV_WR, ACK.
REQ-016 IDLE: req0/req1 are sampled only here; the winner's op/src/dst/wdata are latched; next state is MV_RD for MOVE, otherwise XFER.
REQ-017 Arbitration is round-robin: a lone request wins; on a tie, the requester not granted most recently wins; after reset, requester 0 wins a tie.
REQ-018 XFER, READ: reg_read[src] = 1; rdata captures bus_in at the closing edge.
REQ-019 XFER, WRITE: bus_oe = 1, bus_out = wdata, reg_write[dst] = 1.
REQ-020 XFER, WRITEU: bus_oe = 1, bus_out = wdata, reg_writeu[dst] = 1 (only wdata[7:0] is significant).
REQ-021 MV_RD: reg_read[src] = 1; bus_in is captured into an internal 16-bit temp; next state MV_WR.
REQ-022 MV_WR: bus_oe = 1, bus_out = temp, reg_write[dst] = 1; next state ACK; src == dst is legal and rewrites the same value.
REQ-023 XFER -> ACK; ACK asserts ack[winner] for exactly one cycle, then goes to IDLE.
REQ-024 Latency from req sampled in IDLE to ack high: 2 cycles for READ/WRITE/WRITEU and 3 cycles for MOVE; one transaction completes every 3 or 4 cycles.
REQ-025 All strobes and bus_oe are registered-state decodes and are low in IDLE and ACK.
REQ-026 At most one bit in total of reg_read, reg_write and reg_writeu is high in any cycle.
REQ-027 reg_read and bus_oe are never high in the same cycle (no bus contention).
REQ-028 A request still high in IDLE after its ack is treated as a new transaction.
REQ-029 Input changes outside IDLE have no effect on the transaction in flight.

Reset
REQ-030 While rst_n = 0, asynchronously: state = IDLE, all strobes, bus_oe, ack and busy = 0, rdata = 0, bus_out = 0, temp = 0, round-robin pointer favours requester 0.
REQ-031 Reset mid-transaction aborts it with no ack; register contents are then undefined only for a write whose edge coincides with the reset assertion.
REQ-032 The first request can be sampled at the first posedge after rst_n deasserts.

Structure
REQ-033 Package srp16_regbus_pkg holds the op encodings (OP_READ, OP_WRITE, OP_WRITEU, OP_MOVE) and the FSM state type.
REQ-034 Sub-module rr_arb2 (2-way round-robin arbiter: req[1:0], update, grant one-hot) is instantiated once.
REQ-035 Strobe vectors are decoded from the latched address via a one-hot decode of width NREG.

Verification
REQ-036 Reset, then req0 WRITE dst=3 wdata=16'hBEEF -> ack[0] 2 cycles later, reg_write[3] high for exactly 1 cycle with bus_out=BEEF and bus_oe=1.
REQ-037 req1 READ src=3 with bus_in=16'hBEEF during XFER -> reg_read[3] for 1 cycle, bus_oe=0, rdata=BEEF in the ack[1] cycle.
REQ-038 req0 and req1 held high continuously after reset -> grants alternate 0,1,0,1 with one transaction every 3 cycles.
REQ-039 req0 MOVE src=2 dst=5, bus_in=16'h1234 in MV_RD -> reg_read[2] then reg_write[5] with bus_out=1234, ack[0] 3 cycles after the sample.
REQ-040 req0 WRITEU dst=7 wdata=16'h00A5 -> reg_writeu[7] with bus_out[7:0]=A5; then rst_n low during the XFER of a WRITE -> all strobes low immediately, no ack, busy=0.
REQ-041 All scenarios: an assertion checks REQ-026/REQ-027 on every cycle.
